// File: rtl/uc_sequencer.sv
// uc_sequencer: fetch/execute sequencer owning pc, fetch register, phase toggle and C/Z flags
// Ports: clk, reset (async active-low), en (advance enable), prog_byte (opcode/operand at pc),
//   jump_addr (branch target), ctrl (ROM control word: [12] incPC, [11] loadPC, [9] loadFlags),
//   alu_c/alu_z (ALU flags in), rom_addr ({opcode,C,Z,phase}), rom_en, pc, operand, phase, flag_c, flag_z.
// Optional: define UC_STEP_EN to add step_mode/step single-step inputs.
module uc_sequencer #(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
`ifdef UC_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  input  logic [7:0]      prog_byte,
  input  logic [PC_W-1:0] jump_addr,
  input  logic [12:0]     ctrl,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [6:0]      rom_addr,
  output logic            rom_en,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      operand,
  output logic            phase,
  output logic            flag_c,
  output logic            flag_z
);
  logic [7:0] fetch;
  logic       adv;
  logic       ctrl_unused;
`ifdef UC_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) step_q <= 1'b0;
    else step_q <= step;
  // single step: one phase per rising edge of step, still gated by en
  assign adv = en & (~step_mode | (step & ~step_q));
`else
  assign adv = en;
`endif
  assign ctrl_unused = ^{ctrl[10], ctrl[8:0]};
  assign rom_en      = en;
  assign rom_addr    = {fetch[7:4], flag_c, flag_z, phase};
  assign operand     = fetch[3:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc     <= RST_VEC;
      fetch  <= 8'h00;
      phase  <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (adv) begin
      phase <= ~phase;
      if (!phase) fetch <= prog_byte;
      pc <= ctrl[11] ? jump_addr : ctrl[12] ? pc + PC_W'(1) : pc;
      if (ctrl[9]) {flag_c, flag_z} <= {alu_c, alu_z};
    end
endmodule
